// File: rtl/vga_text_writer.sv
// rtl/vga_text_writer.sv - terminal-style character writer for the VGA text symbol memory
//
// Accepts 8-bit character codes on a valid/ready handshake and drives the write
// port of an 80x35 symbol RAM (address = row*COLS + column) like a terminal cursor:
// printable codes are written, LF/CR/BS are interpreted, lines wrap, and the row
// entered by a newline is cleared. A clr pulse in IDLE blanks the whole screen.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   char_valid/char_data        character source
//   char_ready                  combinational accept (IDLE and no clr)
//   clr                         full-screen clear pulse, honoured only in IDLE
//   mem_we/mem_addr/mem_wdata   registered symbol memory write port
//   cur_x, cur_y                cursor column and row
//   busy                        high whenever the FSM is not IDLE
module vga_text_writer #(
    parameter int COLS = 80,
    parameter int ROWS = 35,
    parameter int AW = 12,
    parameter logic [7:0] SPACE = 8'h20
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          char_valid,
    input  logic [7:0]    char_data,
    output logic          char_ready,
    input  logic          clr,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic [6:0]    cur_x,
    output logic [5:0]    cur_y,
    output logic          busy
);

    localparam logic [6:0]    X_LAST     = 7'(COLS - 1);
    localparam logic [5:0]    Y_LAST     = 6'(ROWS - 1);
    localparam logic [AW-1:0] ROW_STEP   = AW'(COLS);
    localparam logic [AW-1:0] LCLR_LAST  = AW'(COLS - 1);
    localparam logic [AW-1:0] FCLR_LAST  = AW'(COLS * ROWS - 1);
    localparam logic [AW-1:0] ONE        = AW'(1);

    typedef enum logic [1:0] {IDLE, WR, LCLR, FCLR} state_t;

    state_t        state_q, state_d;
    logic [6:0]    cur_x_q, cur_x_d;
    logic [5:0]    cur_y_q, cur_y_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          nl_q, nl_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic          newline;

    assign char_ready = (state_q == IDLE) && !clr;
    assign busy       = (state_q != IDLE);
    assign cur_x      = cur_x_q;
    assign cur_y      = cur_y_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

    // The character is decoded on the accepting edge so that its write and the
    // cursor move are both visible in the following (WR) cycle; nl_q carries the
    // newline decision into WR so the row clear can start right after it.
    always_comb begin
        state_d     = state_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        row_base_d  = row_base_q;
        cnt_d       = cnt_q;
        nl_d        = nl_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        newline     = 1'b0;

        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d     = FCLR;
                    cnt_d       = '0;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = '0;
                    mem_wdata_d = SPACE;
                end else if (char_valid) begin
                    state_d = WR;
                    nl_d    = 1'b0;
                    if (char_data >= 8'h20 && char_data <= 8'h7E) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = row_base_q + AW'(cur_x_q);
                        mem_wdata_d = char_data;
                        if (cur_x_q < X_LAST) cur_x_d = cur_x_q + 7'd1;
                        else                  newline = 1'b1;
                    end else begin
                        case (char_data)
                            8'h0A: newline = 1'b1;
                            8'h0D: cur_x_d = '0;
                            8'h08: begin
                                if (cur_x_q != '0) begin
                                    cur_x_d     = cur_x_q - 7'd1;
                                    mem_we_d    = 1'b1;
                                    mem_addr_d  = row_base_q + AW'(cur_x_q - 7'd1);
                                    mem_wdata_d = SPACE;
                                end
                            end
                            default: ;
                        endcase
                    end
                    if (newline) begin
                        cur_x_d = '0;
                        nl_d    = 1'b1;
                        if (cur_y_q == Y_LAST) begin
                            cur_y_d    = '0;
                            row_base_d = '0;
                        end else begin
                            cur_y_d    = cur_y_q + 6'd1;
                            row_base_d = row_base_q + ROW_STEP;
                        end
                    end
                end
            end
            WR: begin
                if (nl_q) begin
                    state_d     = LCLR;
                    cnt_d       = '0;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = row_base_q;
                    mem_wdata_d = SPACE;
                end else begin
                    state_d = IDLE;
                end
            end
            // cnt_q is the column offset of the write currently on the port.
            LCLR: begin
                if (cnt_q == LCLR_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d      = cnt_q + ONE;
                    mem_we_d   = 1'b1;
                    mem_addr_d = row_base_q + cnt_q + ONE;
                end
            end
            FCLR: begin
                if (cnt_q == FCLR_LAST) begin
                    state_d    = IDLE;
                    cur_x_d    = '0;
                    cur_y_d    = '0;
                    row_base_d = '0;
                end else begin
                    cnt_d      = cnt_q + ONE;
                    mem_we_d   = 1'b1;
                    mem_addr_d = cnt_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            row_base_q  <= '0;
            cnt_q       <= '0;
            nl_q        <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            row_base_q  <= row_base_d;
            cnt_q       <= cnt_d;
            nl_q        <= nl_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_vga_text_writer.sv
// tb/tb_vga_text_writer.sv - self-checking bench for vga_text_writer
module tb_vga_text_writer;

    localparam int COLS = 80;
    localparam int ROWS = 35;
    localparam int CELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        clr = 1'b0;
    logic        char_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [6:0]  cur_x;
    logic [5:0]  cur_y;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Terminal model: cursor, screen image and the ordered list of writes it implies.
    int         mx, my;
    logic [7:0] model_mem [0:4095];
    int         exp_a[$];
    logic [7:0] exp_d[$];

    // Captured DUT write stream and memory image.
    int         got_a[$];
    logic [7:0] got_d[$];
    logic [7:0] tb_mem [0:4095];
    int         max_addr = 0;

    vga_text_writer #(.COLS(COLS), .ROWS(ROWS), .AW(12), .SPACE(8'h20)) dut (
        .clk(clk), .resetn(resetn), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready), .clr(clr), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (resetn && mem_we) begin
            got_a.push_back(int'(mem_addr));
            got_d.push_back(mem_wdata);
            tb_mem[mem_addr] <= mem_wdata;
            if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
        end
    end

    function automatic void model_write(int a, logic [7:0] d);
        exp_a.push_back(a);
        exp_d.push_back(d);
        model_mem[a] = d;
    endfunction

    function automatic void model_newline();
        mx = 0;
        my = (my + 1) % ROWS;
        for (int i = 0; i < COLS; i++) model_write(my * COLS + i, 8'h20);
    endfunction

    function automatic void model_char(logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            model_write(my * COLS + mx, c);
            if (mx < COLS - 1) mx = mx + 1;
            else model_newline();
        end else if (c == 8'h0A) begin
            model_newline();
        end else if (c == 8'h0D) begin
            mx = 0;
        end else if (c == 8'h08 && mx > 0) begin
            mx = mx - 1;
            model_write(my * COLS + mx, 8'h20);
        end
    endfunction

    function automatic void model_fclr();
        for (int a = 0; a < CELLS; a++) model_write(a, 8'h20);
        mx = 0;
        my = 0;
    endfunction

    task automatic clear_logs();
        got_a.delete(); got_d.delete(); exp_a.delete(); exp_d.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        char_valid = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        mx = 0;
        my = 0;
        clear_logs();
    endtask

    task automatic wait_idle(output int busy_cycles);
        busy_cycles = 0;
        while (busy && busy_cycles < 4000) begin
            @(negedge clk);
            busy_cycles++;
        end
        if (busy) begin
            errors++;
            $display("FAIL wait_idle timeout busy=%0b", busy);
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        int n;
        int bc;
        @(negedge clk);
        char_valid = 1'b1;
        char_data = c;
        n = 0;
        while (!char_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) begin
            errors++;
            $display("FAIL send_char ready timeout");
        end
        @(negedge clk);
        char_valid = 1'b0;
        model_char(c);
        wait_idle(bc);
    endtask

    task automatic test_reset();
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %0b exp 0", mem_we); end
        checks++; if (mem_addr !== 12'd0) begin errors++; $display("FAIL rst_addr got %0d exp 0", mem_addr); end
        checks++; if (mem_wdata !== 8'd0) begin errors++; $display("FAIL rst_wdata got %0h exp 0", mem_wdata); end
        checks++; if (cur_x !== 7'd0 || cur_y !== 6'd0) begin errors++; $display("FAIL rst_cursor got (%0d,%0d) exp (0,0)", cur_x, cur_y); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
        checks++; if (char_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b exp 1", char_ready); end
        do_reset();
    endtask

    task automatic test_single_char();
        @(negedge clk);
        char_valid = 1'b1;
        char_data = 8'h41;
        #1;
        checks++; if (char_ready !== 1'b1) begin errors++; $display("FAIL a_ready_idle got %0b exp 1", char_ready); end
        @(negedge clk);
        char_valid = 1'b0;
        #1;
        checks++; if (char_ready !== 1'b0) begin errors++; $display("FAIL a_ready_wr got %0b exp 0", char_ready); end
        checks++; if (mem_we !== 1'b1 || mem_addr !== 12'd0 || mem_wdata !== 8'h41) begin
            errors++; $display("FAIL a_write got we=%0b addr=%0d data=%0h exp we=1 addr=0 data=41", mem_we, mem_addr, mem_wdata); end
        checks++; if (cur_x !== 7'd1 || cur_y !== 6'd0) begin errors++; $display("FAIL a_cursor got (%0d,%0d) exp (1,0)", cur_x, cur_y); end
        @(negedge clk);
        #1;
        checks++; if (mem_we !== 1'b0 || char_ready !== 1'b1) begin
            errors++; $display("FAIL a_after got we=%0b ready=%0b exp we=0 ready=1", mem_we, char_ready); end
        model_char(8'h41);
    endtask

    task automatic test_line_wrap();
        int bc;
        int n;
        int mism;
        int first;
        logic [7:0] c;
        do_reset();
        for (int i = 0; i < COLS - 1; i++) send_char(8'($urandom_range(8'h20, 8'h7E)));
        c = 8'($urandom_range(8'h20, 8'h7E));
        @(negedge clk);
        char_valid = 1'b1;
        char_data = c;
        @(negedge clk);
        char_valid = 1'b0;
        model_char(c);
        bc = 0;
        n = 0;
        while (busy && bc < 4000) begin
            if (char_ready) n++;
            @(negedge clk);
            bc++;
        end
        checks++; if (bc != COLS + 1) begin errors++; $display("FAIL wrap_busy_cycles got %0d exp %0d", bc, COLS + 1); end
        checks++; if (n != 0) begin errors++; $display("FAIL wrap_ready_while_busy got %0d exp 0", n); end
        checks++; if (cur_x !== 7'd0 || cur_y !== 6'd1) begin errors++; $display("FAIL wrap_cursor got (%0d,%0d) exp (0,1)", cur_x, cur_y); end
        checks++;
        if (got_a.size() != exp_a.size()) begin
            errors++; $display("FAIL wrap_write_count got %0d exp %0d", got_a.size(), exp_a.size());
        end else begin
            mism = 0; first = -1;
            foreach (exp_a[i]) if (got_a[i] != exp_a[i] || got_d[i] !== exp_d[i]) begin mism++; if (first < 0) first = i; end
            if (mism != 0) begin errors++; $display("FAIL wrap_writes idx %0d got %0d/%0h exp %0d/%0h", first, got_a[first], got_d[first], exp_a[first], exp_d[first]); end
        end
        checks++; if (got_a.size() > COLS && got_a[COLS - 1] != COLS - 1) begin
            errors++; $display("FAIL wrap_last_char_addr got %0d exp %0d", got_a[COLS - 1], COLS - 1); end
    endtask

    task automatic test_bottom_wrap();
        int mism;
        int first;
        do_reset();
        for (int i = 0; i < ROWS - 1; i++) send_char(8'h0A);
        for (int i = 0; i < 5; i++) send_char(8'h78);
        checks++; if (cur_x !== 7'd5 || cur_y !== 6'd34) begin errors++; $display("FAIL bot_pre_cursor got (%0d,%0d) exp (5,34)", cur_x, cur_y); end
        clear_logs();
        send_char(8'h0A);
        checks++; if (cur_x !== 7'd0 || cur_y !== 6'd0) begin errors++; $display("FAIL bot_cursor got (%0d,%0d) exp (0,0)", cur_x, cur_y); end
        checks++;
        if (got_a.size() != COLS) begin
            errors++; $display("FAIL bot_write_count got %0d exp %0d", got_a.size(), COLS);
        end else begin
            mism = 0; first = -1;
            foreach (exp_a[i]) if (got_a[i] != exp_a[i] || got_d[i] !== exp_d[i] || got_a[i] != i) begin mism++; if (first < 0) first = i; end
            if (mism != 0) begin errors++; $display("FAIL bot_writes idx %0d got %0d/%0h exp %0d/20", first, got_a[first], got_d[first], first); end
        end
    endtask

    task automatic test_backspace();
        send_char(8'h0A);
        send_char(8'h0A);
        send_char(8'h61);
        send_char(8'h62);
        send_char(8'h63);
        checks++; if (cur_x !== 7'd3 || cur_y !== 6'd2) begin errors++; $display("FAIL bs_pre_cursor got (%0d,%0d) exp (3,2)", cur_x, cur_y); end
        clear_logs();
        send_char(8'h08);
        checks++; if (got_a.size() != 1 || got_a[0] != 162 || got_d[0] !== 8'h20) begin
            errors++; $display("FAIL bs_write got count=%0d exp one write of 20 at 162", got_a.size()); end
        checks++; if (cur_x !== 7'd2 || cur_y !== 6'd2) begin errors++; $display("FAIL bs_cursor got (%0d,%0d) exp (2,2)", cur_x, cur_y); end
        send_char(8'h0D);
        checks++; if (cur_x !== 7'd0 || cur_y !== 6'd2) begin errors++; $display("FAIL cr_cursor got (%0d,%0d) exp (0,2)", cur_x, cur_y); end
        send_char(8'h08);
        checks++; if (got_a.size() != 1) begin errors++; $display("FAIL bs_x0_writes got %0d exp 1", got_a.size()); end
        checks++; if (cur_x !== 7'd0 || cur_y !== 6'd2) begin errors++; $display("FAIL bs_x0_cursor got (%0d,%0d) exp (0,2)", cur_x, cur_y); end
    endtask

    task automatic test_full_clear();
        int bc;
        int mism;
        int first;
        clear_logs();
        @(negedge clk);
        clr = 1'b1;
        char_valid = 1'b1;
        char_data = 8'h5A;
        #1;
        checks++; if (char_ready !== 1'b0) begin errors++; $display("FAIL fclr_ready_with_clr got %0b exp 0", char_ready); end
        @(negedge clk);
        clr = 1'b0;
        model_fclr();
        wait_idle(bc);
        checks++; if (bc != CELLS) begin errors++; $display("FAIL fclr_busy_cycles got %0d exp %0d", bc, CELLS); end
        checks++; if (cur_x !== 7'd0 || cur_y !== 6'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL fclr_done got (%0d,%0d) busy=%0b exp (0,0) busy=0", cur_x, cur_y, busy); end
        checks++; if (got_a.size() != CELLS) begin errors++; $display("FAIL fclr_write_count got %0d exp %0d", got_a.size(), CELLS); end
        #1;
        checks++; if (char_ready !== 1'b1) begin errors++; $display("FAIL fclr_ready_after got %0b exp 1", char_ready); end
        @(negedge clk);
        char_valid = 1'b0;
        model_char(8'h5A);
        wait_idle(bc);
        checks++;
        if (got_a.size() != exp_a.size()) begin
            errors++; $display("FAIL fclr_total_writes got %0d exp %0d", got_a.size(), exp_a.size());
        end else begin
            mism = 0; first = -1;
            foreach (exp_a[i]) if (got_a[i] != exp_a[i] || got_d[i] !== exp_d[i]) begin mism++; if (first < 0) first = i; end
            if (mism != 0) begin errors++; $display("FAIL fclr_writes idx %0d got %0d/%0h exp %0d/%0h", first, got_a[first], got_d[first], exp_a[first], exp_d[first]); end
        end
    endtask

    task automatic test_random();
        int mism;
        int first;
        int r;
        logic [7:0] c;
        clear_logs();
        for (int i = 0; i < 160; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      c = 8'($urandom_range(8'h20, 8'h7E));
            else if (r < 80) c = 8'h0A;
            else if (r < 88) c = 8'h0D;
            else if (r < 96) c = 8'h08;
            else             c = 8'($urandom_range(8'h80, 8'hFF));
            send_char(c);
        end
        checks++; if (int'(cur_x) != mx || int'(cur_y) != my) begin
            errors++; $display("FAIL rand_cursor got (%0d,%0d) exp (%0d,%0d)", cur_x, cur_y, mx, my); end
        checks++;
        if (got_a.size() != exp_a.size()) begin
            errors++; $display("FAIL rand_write_count got %0d exp %0d", got_a.size(), exp_a.size());
        end else begin
            mism = 0; first = -1;
            foreach (exp_a[i]) if (got_a[i] != exp_a[i] || got_d[i] !== exp_d[i]) begin mism++; if (first < 0) first = i; end
            if (mism != 0) begin errors++; $display("FAIL rand_writes idx %0d got %0d/%0h exp %0d/%0h", first, got_a[first], got_d[first], exp_a[first], exp_d[first]); end
        end
        mism = 0; first = -1;
        for (int a = 0; a < CELLS; a++) if (tb_mem[a] !== model_mem[a]) begin mism++; if (first < 0) first = a; end
        checks++; if (mism != 0) begin errors++; $display("FAIL rand_screen %0d cells differ, first %0d got %0h exp %0h", mism, first, tb_mem[first], model_mem[first]); end
        checks++; if (max_addr > CELLS - 1) begin errors++; $display("FAIL addr_range got %0d exp <= %0d", max_addr, CELLS - 1); end
    endtask

    task automatic test_reset_mid_fclr();
        int bc;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (1000) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0 || mem_addr !== 12'd0 || mem_wdata !== 8'd0) begin
            errors++; $display("FAIL midrst_port got we=%0b addr=%0d data=%0h exp 0/0/0", mem_we, mem_addr, mem_wdata); end
        checks++; if (busy !== 1'b0 || cur_x !== 7'd0 || cur_y !== 6'd0) begin
            errors++; $display("FAIL midrst_state got busy=%0b (%0d,%0d) exp 0 (0,0)", busy, cur_x, cur_y); end
        @(negedge clk);
        resetn = 1'b1;
        mx = 0;
        my = 0;
        clear_logs();
        send_char(8'h51);
        wait_idle(bc);
        checks++; if (got_a.size() != 1 || got_a[0] != 0 || got_d[0] !== 8'h51) begin
            errors++; $display("FAIL midrst_next got count=%0d exp one write of 51 at 0", got_a.size()); end
        checks++; if (cur_x !== 7'd1 || cur_y !== 6'd0) begin errors++; $display("FAIL midrst_cursor got (%0d,%0d) exp (1,0)", cur_x, cur_y); end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) begin
            model_mem[a] = 8'h00;
            tb_mem[a] = 8'h00;
        end
        mx = 0;
        my = 0;
        test_reset();
        test_single_char();
        test_line_wrap();
        test_bottom_wrap();
        test_backspace();
        test_full_clear();
        test_random();
        test_reset_mid_fclr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_text_writer.md
Name: vga_text_writer

Overview:
Writer side of the VGA text-mode symbol memory. The display scanner reads this memory as an 80x35 grid of 8x15 symbols, with address = row*80 + column. This block accepts a stream of 8-bit character codes over a valid/ready handshake and behaves like a terminal cursor: it writes printable codes into the memory, interprets control codes, wraps lines and clears rows or the whole screen. It sits between a debug/CPU character source and the write port of the symbol RAM.

Parameters:
COLS, 80, symbols per row
ROWS, 35, rows per screen
AW, 12, symbol memory address width (must satisfy COLS*ROWS <= 2**AW)
SPACE, 8'h20, fill code used by every clear operation

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
char_valid  in  1  source has a character
char_data  in  8  character code
char_ready  out  1  block accepts char_data this cycle
clr  in  1  full-screen clear request, one-cycle pulse
mem_we  out  1  symbol memory write enable
mem_addr  out  AW  symbol memory write address
mem_wdata  out  8  symbol memory write data
cur_x  out  7  cursor column, 0..COLS-1
cur_y  out  6  cursor row, 0..ROWS-1
busy  out  1  block is in any state other than IDLE

Behaviour:
- Reset and clocking: one clock; reset is asynchronous and active-low. Reset forces state=IDLE, cur_x=0, cur_y=0, row_base=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0. Reset mid-operation aborts the operation immediately. Memory contents are not touched by reset.
- State machine: IDLE, WR, LCLR (line clear), FCLR (full clear).
- Handshake: char_ready = (state==IDLE) && !clr, and it is combinational. A transfer happens when char_valid && char_ready. If clr and char_valid are both high in IDLE, clr wins and the character is not accepted.
- row_base = cur_y*COLS. It is kept incrementally (+COLS per row, reset to 0 on wrap). No multiplier.
- mem_we, mem_addr and mem_wdata are registered. The write for a character accepted in cycle N appears in cycle N+1 (the WR state). The cursor updates in that same cycle N+1.
- Character decode, applied in WR:
  - 0x20..0x7E: write code at row_base+cur_x. If cur_x < COLS-1, then cur_x+1 and go to IDLE. Otherwise perform a newline.
  - 0x0A (LF): no write; newline.
  - 0x0D (CR): no write; cur_x=0; go to IDLE.
  - 0x08 (BS): if cur_x>0, cur_x-1 and write SPACE at the new position. If cur_x==0, no write and no movement. Go to IDLE.
  - All other codes: accepted, no write, no cursor change, go to IDLE.
- Newline: cur_x=0. cur_y+1 and row_base+COLS, except when cur_y==ROWS-1, in which case cur_y=0 and row_base=0. Then go to LCLR.
- LCLR: writes SPACE to row_base+0 .. row_base+COLS-1, one per cycle, mem_we=1 for exactly COLS cycles, then IDLE.
- FCLR: entered from IDLE when clr=1. Writes SPACE to addresses 0 .. COLS*ROWS-1, one per cycle (2800 cycles at default). After the last write, cur_x=0, cur_y=0, row_base=0, then IDLE.
- clr outside IDLE is ignored; the source must check busy.
- Throughput: a plain character takes 2 cycles (accept + WR). A newline adds COLS cycles.
- mem_we is 0 in IDLE and for non-writing WR cycles. mem_addr and mem_wdata hold their last values when mem_we=0.
- Addresses never exceed COLS*ROWS-1.

Test Plan:
- Reset, then send 'A' (0x41) -> char_ready drops for 1 cycle; mem_we=1 with addr 0, data 0x41; cur_x=1, cur_y=0.
- 80 printable chars from (0,0) -> the last one written at addr 79; cursor (0,1); LCLR writes 0x20 to addrs 80..159 (80 cycles of mem_we); char_ready low throughout.
- Cursor at (5,34), send LF -> cursor (0,0); LCLR writes addrs 0..79; no write to row 35.
- Cursor at (3,2): send BS -> write 0x20 at addr 162, cursor (2,2). Then CR -> cursor (0,2), no write. Then BS at x=0 -> no write.
- Pulse clr together with char_valid in IDLE -> char not accepted; 2800 consecutive writes of 0x20 to addrs 0..2799; cursor (0,0); busy low afterwards; the held character is then accepted.
- Assert resetn low midway through FCLR -> all outputs go to reset values within the same cycle; after release, the next char is written at addr 0.
